// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter sharing one RegisterFile write port and read port A
// between two clients. Optional post-reset zeroing sweep: RF_INIT_SWEEP_EN.
module regfile_access_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic              c0_gnt,
  output logic              c0_rvalid,
  output logic [DATA_W-1:0] c0_rdata,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_gnt,
  output logic              c1_rvalid,
  output logic [DATA_W-1:0] c1_rdata,
  output logic [ADDR_W-1:0] rf_addr_a,
  input  logic [DATA_W-1:0] rf_r_data_a,
  output logic [ADDR_W-1:0] rf_addr_w,
  output logic              rf_write_reg,
  output logic [DATA_W-1:0] rf_w_data,
  output logic              busy
);

  localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

  logic              sweep;
  logic [ADDR_W-1:0] sweep_addr;

`ifdef RF_INIT_SWEEP_EN
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {INIT, SERVE} state_e;
  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= INIT;
      cnt_q   <= ADDR_W'(1);
    end else if (state_q == INIT) begin
      if (cnt_q == LAST) state_q <= SERVE;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Gated by Reset so nothing is written while reset is held
  assign sweep      = Reset && (state_q == INIT);
  assign sweep_addr = cnt_q;
  assign busy       = (state_q == INIT);
`else
  assign sweep      = 1'b0;
  assign sweep_addr = '0;
  assign busy       = 1'b0;
`endif

  logic              ptr_q;
  logic              serve;
  logic              gnt;
  logic              we_s;
  logic              wr_ok;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] wdata_s;
  logic              rv0_q, rv1_q;
  logic [DATA_W-1:0] rd0_q, rd1_q;

  assign serve  = Reset && !sweep;
  assign c0_gnt = serve && c0_req && (!c1_req || !ptr_q);
  assign c1_gnt = serve && c1_req && (!c0_req || ptr_q);
  assign gnt    = c0_gnt || c1_gnt;

  assign we_s    = c1_gnt ? c1_we    : c0_we;
  assign addr_s  = c1_gnt ? c1_addr  : c0_addr;
  assign wdata_s = c1_gnt ? c1_wdata : c0_wdata;

  // R0 is hard zero; addresses past the file are dropped too
  assign wr_ok = (addr_s != '0) && ({1'b0, addr_s} < NREGS);

  always_comb begin
    rf_addr_a    = '0;
    rf_addr_w    = '0;
    rf_w_data    = '0;
    rf_write_reg = 1'b0;
    if (sweep) begin
      rf_addr_w    = sweep_addr;
      rf_write_reg = 1'b1;
    end else if (gnt && we_s) begin
      rf_addr_w    = addr_s;
      rf_w_data    = wdata_s;
      rf_write_reg = wr_ok;
    end else if (gnt) begin
      rf_addr_a = addr_s;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ptr_q <= 1'b0;
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      if (c0_gnt)      ptr_q <= 1'b1;
      else if (c1_gnt) ptr_q <= 1'b0;
      rv0_q <= c0_gnt && !c0_we;
      rv1_q <= c1_gnt && !c1_we;
      if (c0_gnt && !c0_we) rd0_q <= rf_r_data_a;
      if (c1_gnt && !c1_we) rd1_q <= rf_r_data_a;
    end
  end

  assign c0_rvalid = rv0_q;
  assign c1_rvalid = rv1_q;
  assign c0_rdata  = rd0_q;
  assign c1_rdata  = rd1_q;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter: RF model, read-data scoreboard,
// directed steps for writes, reads, alternation, R0, reset and sweep.
module tb_regfile_access_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          c0_req, c0_we, c1_req, c1_we;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [DW-1:0] c0_wdata, c1_wdata;
  logic          c0_gnt, c0_rvalid, c1_gnt, c1_rvalid;
  logic [DW-1:0] c0_rdata, c1_rdata;
  logic [AW-1:0] rf_addr_a, rf_addr_w;
  logic [DW-1:0] rf_r_data_a, rf_w_data;
  logic          rf_write_reg, busy;

  regfile_access_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr),
    .c0_wdata(c0_wdata), .c0_gnt(c0_gnt),
    .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr),
    .c1_wdata(c1_wdata), .c1_gnt(c1_gnt),
    .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
    .rf_addr_a(rf_addr_a), .rf_r_data_a(rf_r_data_a),
    .rf_addr_w(rf_addr_w), .rf_write_reg(rf_write_reg),
    .rf_w_data(rf_w_data), .busy(busy)
  );

  always #5 Clk = ~Clk;

  logic [DW-1:0] rf [32];
  logic [DW-1:0] sh [32];
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];
  int pass_n = 0;
  int tot_n  = 0;
  int fail_n = 0;

  assign rf_r_data_a = rf[rf_addr_a];
  always @(posedge Clk) if (rf_write_reg) rf[rf_addr_w] <= rf_w_data;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tot_n++;
    assert (obs === exp) pass_n++;
    else begin
      fail_n++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (c0_rvalid) begin
      if (q0.size() == 0) chk("c0_rvalid_unexpected", 1, 0);
      else chk("c0_rdata", c0_rdata, q0.pop_front());
    end
    if (c1_rvalid) begin
      if (q1.size() == 0) chk("c1_rvalid_unexpected", 1, 0);
      else chk("c1_rdata", c1_rdata, q1.pop_front());
    end
  end

  task automatic idle_reqs();
    c0_req = 0; c0_we = 0; c0_addr = '0; c0_wdata = '0;
    c1_req = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("busy_timeout", busy, 0);
  endtask

  task automatic do_reset();
    idle_reqs();
    Reset = 0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1;
`ifdef RF_INIT_SWEEP_EN
    for (int i = 1; i < 32; i++) sh[i] = '0;
`endif
    wait_ready();
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after grant
  task automatic access(input bit c, input bit we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    logic g;
    if (c) begin c1_req = 1; c1_we = we; c1_addr = a; c1_wdata = d; end
    else   begin c0_req = 1; c0_we = we; c0_addr = a; c0_wdata = d; end
    @(negedge Clk);
    g = c ? c1_gnt : c0_gnt;
    while (!g && n < 20) begin
      @(negedge Clk);
      g = c ? c1_gnt : c0_gnt;
      n++;
    end
    chk("gnt", g, 1);
    if (we) begin
      chk("wr_en", rf_write_reg, a != 0);
      if (a != 0) begin
        chk("wr_addr", rf_addr_w, a);
        chk("wr_data", rf_w_data, d);
        sh[a] = d;
      end
    end else begin
      chk("rd_addr", rf_addr_a, a);
      if (c) q1.push_back(sh[a]);
      else   q0.push_back(sh[a]);
    end
    @(posedge Clk); #1;
    if (c) c1_req = 0; else c0_req = 0;
    chk("rvalid_latency", c ? c1_rvalid : c0_rvalid, !we);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin rf[i] = '0; sh[i] = '0; end
    idle_reqs();
    #2;
    chk("rst_gnt", {c0_gnt, c1_gnt}, 0);
    chk("rst_rvalid", {c0_rvalid, c1_rvalid}, 0);
    chk("rst_rdata", {c0_rdata, c1_rdata}, 0);
    chk("rst_rf_out", {rf_addr_a, rf_addr_w, rf_write_reg, rf_w_data}, 0);
`ifdef RF_INIT_SWEEP_EN
    chk("rst_busy", busy, 1);
`else
    chk("rst_busy", busy, 0);
`endif
    @(posedge Clk); #1 Reset = 1;
    wait_ready();

    @(negedge Clk);
    chk("idle_gnt", {c0_gnt, c1_gnt, rf_write_reg}, 0);
    @(posedge Clk); #1;

    access(0, 1, 5'd3, 32'h0000_0003);
    access(0, 0, 5'd3, '0);

    for (int i = 1; i <= 6; i++)
      access(0, 1, AW'(i), DW'(32'h100 * i + i));

    do_reset();
    c0_req = 1; c0_we = 0; c0_addr = 5'd1;
    c1_req = 1; c1_we = 0; c1_addr = 5'd4;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      chk("alt_g0", c0_gnt, i % 2 == 0);
      chk("alt_g1", c1_gnt, i % 2 == 1);
      if (c0_gnt) q0.push_back(sh[c0_addr]);
      if (c1_gnt) q1.push_back(sh[c1_addr]);
      @(posedge Clk); #1;
      if (i % 2 == 0) c0_addr = c0_addr + 1'b1;
      else            c1_addr = c1_addr + 1'b1;
    end
    idle_reqs();
    @(posedge Clk); #1;

    access(1, 1, 5'd0, 32'hFFFF_FFFF);
    access(1, 0, 5'd0, '0);

    access(0, 1, 5'd5, 32'h1111_1234);
    access(1, 0, 5'd5, '0);
    access(1, 0, 5'd2, '0);

    c0_req = 1; c0_we = 0; c0_addr = 5'd3;
    @(negedge Clk);
    chk("rst_mid_gnt", c0_gnt, 1);
    #2 Reset = 0;
    #1;
    chk("rst_mid_out", {c0_gnt, c0_rvalid, c1_rvalid, rf_write_reg}, 0);
    chk("rst_mid_data", {c0_rdata, c1_rdata}, 0);
    chk("rst_mid_addr", {rf_addr_a, rf_addr_w}, 0);
    repeat (2) @(posedge Clk);
    #1 idle_reqs();
    Reset = 1;
`ifdef RF_INIT_SWEEP_EN
    for (int i = 1; i < 32; i++) sh[i] = '0;
`endif
    @(negedge Clk);
    chk("rst_mid_no_rvalid", c0_rvalid, 0);
    wait_ready();

`ifdef RF_INIT_SWEEP_EN
    begin
      int n = 0;
      for (int i = 1; i < 32; i++) rf[i] = 32'hDEAD_0000 | i;
      Reset = 0;
      c0_req = 1; c0_we = 0; c0_addr = 5'd7;
      @(posedge Clk); #1 Reset = 1;
      while (busy && n < 100) begin
        @(negedge Clk);
        chk("sweep_no_gnt", c0_gnt, 0);
        chk("sweep_we", rf_write_reg, 1);
        chk("sweep_addr", rf_addr_w, n + 1);
        chk("sweep_data", rf_w_data, 0);
        @(posedge Clk); #1;
        n++;
      end
      chk("sweep_len", n, 31);
      c0_req = 0;
      for (int i = 1; i < 32; i++) sh[i] = '0;
      access(0, 0, 5'd7, '0);
      access(1, 0, 5'd31, '0);
    end
`endif

    repeat (3) @(posedge Clk);
    #1 chk("queues_empty", q0.size() + q1.size(), 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
